// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline / multi-cycle unit / decode stage (master)
// and the register-file write-port arbiter (slave).
//
// Handshakes:
//   wbw_valid / wb_stall : a pipeline write completes in any cycle with
//     wbw_valid & !wb_stall. While wb_stall is high the pipeline holds
//     wbw_valid, wba and wbd unchanged into the next cycle.
//   mc_valid / mc_ready  : a multi-cycle result transfers in any cycle with
//     mc_valid & mc_ready. While mc_valid is high and mc_ready is low the
//     producer holds mc_rd and mc_data stable.
interface regfile_wb_arbiter_if;
  logic        wbw_valid;
  logic [3:0]  wba;
  logic [31:0] wbd;
  logic        wb_stall;

  logic        mc_issue;
  logic [3:0]  mc_issue_rd;
  logic        mc_valid;
  logic [3:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;

  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic        stall_rd;

  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        err;

  modport master (
    output wbw_valid, wba, wbd,
    output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    output ra1, ra2,
    input  wb_stall, mc_ready, stall_rd, we3, wa3, wd3, err
  );

  modport slave (
    input  wbw_valid, wba, wbd,
    input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    input  ra1, ra2,
    output wb_stall, mc_ready, stall_rd, we3, wa3, wd3, err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback and a
// multi-cycle execution unit share one write port. Multi-cycle results are
// queued in a small FIFO; a 15-entry scoreboard tracks destinations still in
// flight so decode can stall on them. An age counter on the FIFO head lets a
// buffered result preempt the pipeline after STARVE_MAX cycles of waiting.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } entry_t;

  // One-hot decode of a register address onto the 15 scoreboard bits.
  // r15 (the PC) is never tracked, so it decodes to all zeros.
  function automatic logic [14:0] reg_mask(input logic [3:0] a);
    return 15'(16'd1 << a);
  endfunction

  // FIFO storage and control
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Head age, scoreboard, sticky error
  logic [GW-1:0] age_q, age_d;
  logic [14:0]   pending_q, pending_d;
  logic          err_q, err_d;

  // Arbitration results
  entry_t        head;
  logic          empty;
  logic          full;
  logic          starve;
  logic          push;
  logic          pop;
  logic          pipe_wr;
  logic          mc_ready;
  logic          we3;
  logic [3:0]    wa3;
  logic [31:0]   wd3;
  logic          wb_stall;
  logic          stall_rd;

  // Scoreboard update masks
  logic [14:0]   set_mask;
  logic [14:0]   clr_mask;

  // Write-port selection: starving head, then pipeline, then idle-cycle drain.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    starve   = !empty && (age_q >= GW'(STARVE_MAX));
    mc_ready = !full && !reset;
    push     = bus.mc_valid && mc_ready;
    pop      = 1'b0;
    pipe_wr  = 1'b0;
    we3      = 1'b0;
    wa3      = 4'd0;
    wd3      = 32'd0;
    wb_stall = 1'b0;
    if (!reset) begin
      if (starve) begin
        pop      = 1'b1;
        we3      = 1'b1;
        wa3      = head.rd;
        wd3      = head.data;
        wb_stall = bus.wbw_valid;
      end else if (bus.wbw_valid) begin
        pipe_wr  = 1'b1;
        we3      = 1'b1;
        wa3      = bus.wba;
        wd3      = bus.wbd;
      end else if (!empty) begin
        pop      = 1'b1;
        we3      = 1'b1;
        wa3      = head.rd;
        wd3      = head.data;
      end
    end
  end

  // FIFO next state. Push never happens while full because mc_ready is
  // derived from the registered count, so a same-cycle pop only frees a slot
  // for the following cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: bus.mc_rd, data: bus.mc_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Head age: restarts whenever the head leaves or nothing is buffered.
  always_comb begin
    age_d = age_q;
    if (pop || empty) begin
      age_d = '0;
    end else if (age_q < GW'(STARVE_MAX)) begin
      age_d = age_q + GW'(1);
    end
  end

  // Scoreboard and protocol checks. A set and clear on the same register in
  // one cycle leaves it pending (the new issue wins).
  always_comb begin
    set_mask  = bus.mc_issue ? reg_mask(bus.mc_issue_rd) : 15'd0;
    clr_mask  = pop ? reg_mask(head.rd) : 15'd0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    err_d     = err_q;
    if (bus.mc_issue && (bus.mc_issue_rd == 4'd15)) begin
      err_d = 1'b1;
    end
    if (|(set_mask & pending_q & ~clr_mask)) begin
      err_d = 1'b1;
    end
    if (pipe_wr && |(reg_mask(bus.wba) & pending_q)) begin
      err_d = 1'b1;
    end
    if (push && !(|(reg_mask(bus.mc_rd) & pending_q))) begin
      err_d = 1'b1;
    end
  end

  // Decode stall from registered scoreboard only; r15 never stalls.
  always_comb begin
    stall_rd = !reset &&
               ((|(reg_mask(bus.ra1) & pending_q)) ||
                (|(reg_mask(bus.ra2) & pending_q)));
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Result storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.mc_ready = mc_ready;
  assign bus.we3      = we3;
  assign bus.wa3      = wa3;
  assign bus.wd3      = wd3;
  assign bus.wb_stall = wb_stall;
  assign bus.stall_rd = stall_rd;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the write port.
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] obs_vec;
  assign obs_vec = {bus.we3, bus.wa3, bus.wd3, bus.wb_stall,
                    bus.mc_ready, bus.stall_rd, bus.err};

  // ---------------- reference model ----------------
  logic [35:0] exp_q[$];          // buffered {rd, data}
  bit          m_pend [15];
  int          m_age  = 0;
  bit          m_err  = 1'b0;
  logic        exp_we3, exp_wb_stall, exp_mc_ready, exp_stall_rd, exp_err;
  logic [3:0]  exp_wa3;
  logic [31:0] exp_wd3;
  logic [40:0] exp_vec;
  bit          m_pop, m_pipe;

  function automatic bit pend_of(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
    return m_pend[a];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      exp_we3 = 0; exp_wa3 = 0; exp_wd3 = 0; exp_wb_stall = 0;
      exp_mc_ready = 0; m_pop = 0; m_pipe = 0;
      if (!reset) begin
        exp_mc_ready = (exp_q.size() < DEPTH);
        if (exp_q.size() > 0 && m_age >= STARVE_MAX) begin
          m_pop = 1; exp_we3 = 1; {exp_wa3, exp_wd3} = exp_q[0];
          exp_wb_stall = bus.wbw_valid;
        end else if (bus.wbw_valid) begin
          m_pipe = 1; exp_we3 = 1; exp_wa3 = bus.wba; exp_wd3 = bus.wbd;
        end else if (exp_q.size() > 0) begin
          m_pop = 1; exp_we3 = 1; {exp_wa3, exp_wd3} = exp_q[0];
        end
      end
      exp_stall_rd = !reset && (pend_of(bus.ra1) || pend_of(bus.ra2));
      exp_err = m_err;
      exp_vec = {exp_we3, exp_wa3, exp_wd3, exp_wb_stall,
                 exp_mc_ready, exp_stall_rd, exp_err};
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_age = 0;
        m_err = 0;
      end else begin
        bit         push;
        logic [3:0] prd;
        push = bus.mc_valid && exp_mc_ready;
        prd  = m_pop ? exp_q[0][35:32] : 4'd15;
        if (bus.mc_issue && bus.mc_issue_rd == 4'd15) m_err = 1;
        if (bus.mc_issue && pend_of(bus.mc_issue_rd) &&
            !(m_pop && prd == bus.mc_issue_rd)) m_err = 1;
        if (m_pipe && pend_of(bus.wba)) m_err = 1;
        if (push && !pend_of(bus.mc_rd)) m_err = 1;
        if (m_pop || exp_q.size() == 0) m_age = 0;
        else if (m_age < STARVE_MAX) m_age = m_age + 1;
        if (m_pop) begin
          if (prd != 4'd15) m_pend[prd] = 0;
          void'(exp_q.pop_front());
        end
        if (bus.mc_issue && bus.mc_issue_rd != 4'd15) m_pend[bus.mc_issue_rd] = 1;
        if (push) exp_q.push_back({bus.mc_rd, bus.mc_data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wbw_valid = 0; bus.wba = 0; bus.wbd = 0;
    bus.mc_issue = 0; bus.mc_issue_rd = 0;
    bus.mc_valid = 0; bus.mc_rd = 0; bus.mc_data = 0;
    bus.ra1 = 4'd15; bus.ra2 = 4'd15;
  endtask

  task automatic apply_reset();
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1;
    idle_inputs();
    tick();
    bus.wbw_valid = 1; bus.wba = 4'd5; bus.wbd = $urandom;
    bus.mc_valid = 1; bus.mc_rd = 4'd2; bus.ra1 = 4'd3;
    sample();
    n_checks++;
    if (obs_vec !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs_vec, 41'd0);
    end
    tick();
    reset = 0;
    idle_inputs();
    sample();
    n_checks++;
    if ({bus.we3, bus.mc_ready, bus.stall_rd, bus.err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 0100",
               {bus.we3, bus.mc_ready, bus.stall_rd, bus.err});
    end
    tick();
  endtask

  task automatic test_idle_issue();
    logic [4:0] stall_exp = 5'b01110;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      bus.ra1 = 4'd3;
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd3; end
      if (c == 2) begin bus.mc_valid = 1; bus.mc_rd = 4'd3; bus.mc_data = 32'hDEADBEEF; end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL idle_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      n_checks++;
      if (bus.stall_rd !== stall_exp[c]) begin
        n_fail++;
        $display("FAIL idle_stall_rd c%0d: got %b expected %b", c, bus.stall_rd, stall_exp[c]);
      end
      if (c == 3) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
          n_fail++;
          $display("FAIL idle_write: got we3=%b wa3=%0d wd3=%h expected 1/3/deadbeef",
                   bus.we3, bus.wa3, bus.wd3);
        end
      end else begin
        n_checks++;
        if (bus.we3 !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_no_write c%0d: got we3=%b expected 0", c, bus.we3);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (bus.err !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_err: got %b expected 0", bus.err);
        end
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [31:0] rdata = $urandom;
    logic [31:0] pdata = $urandom;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      bus.ra1 = 4'd5;
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd5; end
      if (c == 1) begin bus.mc_valid = 1; bus.mc_rd = 4'd5; bus.mc_data = rdata; end
      if (c == 2) begin bus.wbw_valid = 1; bus.wba = 4'd2; bus.wbd = pdata; end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL prio_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 2) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3, bus.wb_stall} !== {1'b1, 4'd2, pdata, 1'b0}) begin
          n_fail++;
          $display("FAIL prio_pipe_first: got wa3=%0d wd3=%h stall=%b expected 2/%h/0",
                   bus.wa3, bus.wd3, bus.wb_stall, pdata);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 4'd5, rdata}) begin
          n_fail++;
          $display("FAIL prio_drain: got we3=%b wa3=%0d wd3=%h expected 1/5/%h",
                   bus.we3, bus.wa3, bus.wd3, rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    logic [31:0] rdata = $urandom;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd7; end
      if (c == 1) begin bus.mc_valid = 1; bus.mc_rd = 4'd7; bus.mc_data = rdata; end
      if (c >= 2 && c <= 7) begin
        bus.wbw_valid = 1;
        bus.wba = (c < 6) ? 4'(c - 1) : 4'd8;
        bus.wbd = 32'h1000 + 32'(bus.wba);
      end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL starve_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wb_stall} !== {1'b1, 4'(c - 1), 1'b0}) begin
          n_fail++;
          $display("FAIL starve_pipe c%0d: got wa3=%0d stall=%b expected %0d/0",
                   c, bus.wa3, bus.wb_stall, c - 1);
        end
      end
      if (c == 6) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3, bus.wb_stall} !== {1'b1, 4'd7, rdata, 1'b1}) begin
          n_fail++;
          $display("FAIL starve_preempt: got wa3=%0d wd3=%h stall=%b expected 7/%h/1",
                   bus.wa3, bus.wd3, bus.wb_stall, rdata);
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3, bus.wb_stall} !== {1'b1, 4'd8, 32'h1008, 1'b0}) begin
          n_fail++;
          $display("FAIL starve_held_write: got wa3=%0d wd3=%h stall=%b expected 8/1008/0",
                   bus.wa3, bus.wd3, bus.wb_stall);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_buffer();
    logic [7:0] rdy_exp = 8'b1000_0111;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd9; end
      if (c == 1) begin
        bus.mc_issue = 1; bus.mc_issue_rd = 4'd10;
        bus.mc_valid = 1; bus.mc_rd = 4'd9; bus.mc_data = 32'h9999_0000;
      end
      if (c == 2) begin bus.mc_valid = 1; bus.mc_rd = 4'd10; bus.mc_data = 32'hAAAA_0000; end
      if (c >= 2 && c <= 7) begin
        bus.wbw_valid = 1;
        bus.wba = (c < 6) ? 4'(c) : 4'd6;
        bus.wbd = 32'(c < 6 ? c : 6);
      end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL full_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c < 8) begin
        n_checks++;
        if (bus.mc_ready !== rdy_exp[c]) begin
          n_fail++;
          $display("FAIL full_mc_ready c%0d: got %b expected %b", c, bus.mc_ready, rdy_exp[c]);
        end
      end
      if (c == 8) begin
        n_checks++;
        if ({bus.we3, bus.wa3, bus.wd3, bus.err} !== {1'b1, 4'd10, 32'hAAAA_0000, 1'b0}) begin
          n_fail++;
          $display("FAIL full_second_drain: got we3=%b wa3=%0d wd3=%h err=%b expected 1/10/aaaa0000/0",
                   bus.we3, bus.wa3, bus.wd3, bus.err);
        end
      end
      tick();
    end
  endtask

  task automatic test_violations();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd15; end
      sample();
      n_checks++;
      if (bus.err !== (c != 0)) begin
        n_fail++;
        $display("FAIL viol_issue_r15 c%0d: got err=%b expected %b", c, bus.err, c != 0);
      end
      tick();
    end
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd4; end
      if (c == 1) begin bus.wbw_valid = 1; bus.wba = 4'd4; bus.wbd = $urandom; end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL viol_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      n_checks++;
      if (bus.err !== (c >= 2)) begin
        n_fail++;
        $display("FAIL viol_waw c%0d: got err=%b expected %b", c, bus.err, c >= 2);
      end
      tick();
    end
    apply_reset();
    sample();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_err_cleared: got %b expected 0", bus.err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      bus.ra1 = 4'd11; bus.ra2 = 4'd12;
      if (c == 0) begin bus.mc_issue = 1; bus.mc_issue_rd = 4'd11; end
      if (c == 1) begin
        bus.mc_issue = 1; bus.mc_issue_rd = 4'd12;
        bus.mc_valid = 1; bus.mc_rd = 4'd11; bus.mc_data = $urandom;
      end
      if (c == 2) begin
        bus.mc_valid = 1; bus.mc_rd = 4'd12; bus.mc_data = $urandom;
        bus.wbw_valid = 1; bus.wba = 4'd1; bus.wbd = $urandom;
      end
      if (c == 3) begin
        reset = 1;
        bus.wbw_valid = 1; bus.wba = 4'd2; bus.wbd = $urandom;
      end
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 3) begin
        n_checks++;
        if ({bus.we3, bus.wb_stall, bus.mc_ready} !== 3'b000) begin
          n_fail++;
          $display("FAIL rstmid_in_reset: got we3/stall/rdy=%b expected 000",
                   {bus.we3, bus.wb_stall, bus.mc_ready});
        end
      end
      if (c >= 4) begin
        n_checks++;
        if ({bus.we3, bus.stall_rd, bus.mc_ready, bus.err} !== 4'b0010) begin
          n_fail++;
          $display("FAIL rstmid_after c%0d: got we3/stall_rd/rdy/err=%b expected 0010",
                   c, {bus.we3, bus.stall_rd, bus.mc_ready, bus.err});
        end
      end
      tick();
      reset = 0;
    end
  endtask

  task automatic test_random();
    logic [3:0] out_q[$];
    bit stalled_last  = 0;
    bit accepted_last = 0;
    bit reset_last    = 0;
    apply_reset();
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (reset_last) begin
        out_q.delete();
        bus.mc_valid = 0;
      end
      if (!(bus.wbw_valid && stalled_last)) begin
        bus.wbw_valid = ($urandom_range(0, 99) < 50);
        bus.wba = 4'($urandom_range(0, 15));
        bus.wbd = $urandom;
      end
      if (bus.mc_valid && accepted_last) bus.mc_valid = 0;
      if (!bus.mc_valid && out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.mc_valid = 1;
        bus.mc_rd = out_q.pop_front();
        bus.mc_data = $urandom;
      end
      bus.mc_issue = ($urandom_range(0, 4) == 0);
      bus.mc_issue_rd = 4'($urandom_range(0, 14));
      if (bus.mc_issue) out_q.push_back(bus.mc_issue_rd);
      bus.ra1 = 4'($urandom_range(0, 15));
      bus.ra2 = 4'($urandom_range(0, 15));
      sample();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model c%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      stalled_last  = exp_wb_stall;
      accepted_last = bus.mc_valid && exp_mc_ready;
      reset_last    = reset;
      tick();
    end
    reset = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_issue();
    test_priority();
    test_starvation();
    test_full_buffer();
    test_violations();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
